// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings, latched command type and grant helper
package mem_port_arbiter_pkg;

    // Arbiter FSM encodings (kept as plain 2-bit constants for legacy compatibility)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    // Read data returned to the requester when the watchdog aborts an access
    localparam logic [31:0] ABORT_RDATA = 32'h0;

    // Command captured at grant time and held on the memory port while busy
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    // Fetch wins when it is the only requester, or when data has starved it
    function automatic logic pick_if(input logic if_req, input logic dm_req,
                                     input logic starved);
        return if_req & (~dm_req | starved);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory handshake bundle
// master: arbiter side (drives completions, waits, memory command, bus_err)
// slave : pipeline/memory side (drives requests, memory read data and ready)
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_wait;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_wait;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        bus_err;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_valid, if_wait, dm_rdata, dm_valid, dm_wait,
               mem_en, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_valid, if_wait, dm_rdata, dm_valid, dm_wait,
               mem_en, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// rtl/mem_port_arbiter_watchdog.sv - busy-cycle counter that flags a memory that never answers
// Ports: clk, reset (sync, active-high); clr restarts the count; en counts one
// stalled busy cycle; expire is high while the count has reached TIMEOUT.
module mem_port_arbiter_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT);

    logic [TW-1:0] tcnt_q;
    logic [TW-1:0] tcnt_d;

    assign expire = (tcnt_q == TLIMIT);

    always_comb begin
        tcnt_d = tcnt_q;
        if (clr) begin
            tcnt_d = '0;
        end else if (en && !expire) begin
            // Hold at the limit; the arbiter leaves BUSY in the same cycle anyway
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for a single-ported unified memory
// Ports: clk, reset (sync, active-high), bus (master modport): fetch and data
// level requests in, one-cycle valid completions and wait levels out, memory
// command out with mem_ready/mem_rdata in, sticky bus_err on watchdog abort.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.master   bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    mem_cmd_t      cmd_q, cmd_d;
    logic          bus_err_q, bus_err_d;

    logic          busy;
    logic          done;
    logic          expire;
    logic          wd_clr;
    logic [31:0]   rd_val;
    logic          if_valid;
    logic          dm_valid;

    mem_port_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (busy & ~bus.mem_ready),
        .expire (expire)
    );

    assign busy = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
    // A ready arriving with the timeout is still a clean completion
    assign done = busy & (bus.mem_ready | expire);

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        cmd_d     = cmd_q;
        bus_err_d = bus_err_q;
        wd_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    wd_clr = 1'b1;
                    if (pick_if(bus.if_req, bus.dm_req, streak_q == STREAK_MAX)) begin
                        state_d  = ST_BUSY_I;
                        streak_d = '0;
                        cmd_d    = '{we: 1'b0, addr: bus.if_addr, wdata: 32'h0};
                    end else begin
                        state_d = ST_BUSY_D;
                        // Only data grants that leave fetch waiting count toward starvation
                        if (bus.if_req && streak_q != STREAK_MAX) begin
                            streak_d = streak_q + 1'b1;
                        end
                        cmd_d = '{we: bus.dm_we, addr: bus.dm_addr, wdata: bus.dm_wdata};
                    end
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (done) begin
                    state_d = ST_IDLE;
                    if (!bus.mem_ready) begin
                        bus_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            streak_q  <= '0;
            cmd_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            cmd_q     <= cmd_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Stores complete with zero data; an abort returns the abort value
    assign rd_val = bus.mem_ready ? (cmd_q.we ? 32'h0 : bus.mem_rdata) : ABORT_RDATA;

    // Valids are suppressed while reset is asserted so a dropped access never completes
    assign if_valid = ~reset & done & (state_q == ST_BUSY_I);
    assign dm_valid = ~reset & done & (state_q == ST_BUSY_D);

    assign bus.if_valid  = if_valid;
    assign bus.dm_valid  = dm_valid;
    assign bus.if_rdata  = if_valid ? rd_val : 32'h0;
    assign bus.dm_rdata  = dm_valid ? rd_val : 32'h0;
    assign bus.if_wait   = bus.if_req & ~if_valid;
    assign bus.dm_wait   = bus.dm_req & ~dm_valid;
    assign bus.mem_en    = busy;
    assign bus.mem_we    = busy & cmd_q.we;
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_wdata = cmd_q.wdata;
    assign bus.bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst, ifr, dmr, we;
        logic [31:0] ia, da, wd;
        logic        rdy;
        logic [31:0] mrd;
        logic        en, mwe;
        logic [31:0] addr, wdat;
        logic        iv, dv;
        logic [31:0] ird, drd;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, ifr, dmr, we,
                                input logic [31:0] ia, da, wd,
                                input logic rdy, input logic [31:0] mrd,
                                input logic en, mwe,
                                input logic [31:0] addr, wdat,
                                input logic iv, dv,
                                input logic [31:0] ird, drd,
                                input logic err);
        vec_t v;
        v.rst = rst; v.ifr = ifr; v.dmr = dmr; v.we = we;
        v.ia = ia; v.da = da; v.wd = wd; v.rdy = rdy; v.mrd = mrd;
        v.en = en; v.mwe = mwe; v.addr = addr; v.wdat = wdat;
        v.iv = iv; v.dv = dv; v.ird = ird; v.drd = drd; v.err = err;
        vecs.push_back(v);
    endfunction

    function automatic logic [134:0] outs();
        return {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                bus.if_valid, bus.dm_valid, bus.if_rdata, bus.dm_rdata,
                bus.if_wait, bus.dm_wait, bus.bus_err};
    endfunction

    task automatic drive(input logic rst, ifr, dmr, we,
                         input logic [31:0] ia, da, wd,
                         input logic rdy, input logic [31:0] mrd);
        reset         = rst;
        bus.if_req    = ifr;
        bus.dm_req    = dmr;
        bus.dm_we     = we;
        bus.if_addr   = ia;
        bus.dm_addr   = da;
        bus.dm_wdata  = wd;
        bus.mem_ready = rdy;
        bus.mem_rdata = mrd;
    endtask

    task automatic chk_vec(input string nm, input logic [134:0] got, input logic [134:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pa, pw;
        logic [31:0] mrd;
        int          cnt;
        logic        seen;

        // Reset state
        add(1,0,0,0, 0,0,0, 0,0,  0,0,0,0, 0,0,0,0, 0);
        // Single load, memory answers on the second busy cycle
        add(0,0,1,0, 0,'h100,0, 0,0,        0,0,0,0, 0,0,0,0, 0);
        add(0,0,1,0, 0,'h100,0, 0,0,        1,0,'h100,0, 0,0,0,0, 0);
        add(0,0,1,0, 0,'h100,0, 1,'h1234,   1,0,'h100,0, 0,1,0,'h1234, 0);
        add(0,0,0,0, 0,0,0, 0,0,            0,0,'h100,0, 0,0,0,0, 0);
        // Store held for three busy cycles
        add(0,0,1,1, 0,'h200,'hCAFEF00D, 0,0,          0,0,'h100,0, 0,0,0,0, 0);
        add(0,0,1,1, 0,'h200,'hCAFEF00D, 0,0,          1,1,'h200,'hCAFEF00D, 0,0,0,0, 0);
        add(0,0,1,1, 0,'h200,'hCAFEF00D, 0,0,          1,1,'h200,'hCAFEF00D, 0,0,0,0, 0);
        add(0,0,1,1, 0,'h200,'hCAFEF00D, 1,'hDEADBEEF, 1,1,'h200,'hCAFEF00D, 0,1,0,0, 0);
        add(0,0,0,0, 0,0,0, 0,0,                       0,0,'h200,'hCAFEF00D, 0,0,0,0, 0);
        // Contention: both held, ready always high (ignored in IDLE); D,D,D,D,I twice
        pa = 'h200; pw = 'hCAFEF00D;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                mrd = 32'h1000 + 32'(r * 16 + k);
                add(0,1,1,0, 'h40,'h300,0, 1,'hAA, 0,0,pa,pw, 0,0,0,0, 0);
                add(0,1,1,0, 'h40,'h300,0, 1,mrd,  1,0,'h300,0, 0,1,0,mrd, 0);
                pa = 'h300; pw = 0;
            end
            mrd = 32'h2000 + 32'(r);
            add(0,1,1,0, 'h40,'h300,0, 1,'hAA, 0,0,'h300,0, 0,0,0,0, 0);
            add(0,1,1,0, 'h40,'h300,0, 1,mrd,  1,0,'h40,0, 1,0,mrd,0, 0);
            pa = 'h40;
        end
        add(0,0,0,0, 0,0,0, 0,0, 0,0,'h40,0, 0,0,0,0, 0);

        drive(1,0,0,0, 0,0,0, 0,0);
        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ifr, vecs[i].dmr, vecs[i].we,
                  vecs[i].ia, vecs[i].da, vecs[i].wd, vecs[i].rdy, vecs[i].mrd);
            @(negedge clk);
            chk_vec($sformatf("vec%0d", i), outs(),
                    {vecs[i].en, vecs[i].mwe, vecs[i].addr, vecs[i].wdat,
                     vecs[i].iv, vecs[i].dv, vecs[i].ird, vecs[i].drd,
                     vecs[i].ifr & ~vecs[i].iv, vecs[i].dmr & ~vecs[i].dv, vecs[i].err});
            step();
        end

        // Timeout on a fetch: memory never answers
        drive(0,1,0,0, 'h80,0,0, 0,0);
        cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.if_valid) begin
                seen = 1'b1;
                break;
            end
            if (bus.mem_en) cnt++;
            step();
        end
        chk("timeout_seen", 32'(seen), 1);
        chk("timeout_latency", cnt, 15);
        chk("timeout_rdata", bus.if_rdata, 0);
        chk("timeout_err_before", 32'(bus.bus_err), 0);
        step();
        drive(0,0,0,0, 0,0,0, 0,0);
        @(negedge clk);
        chk("timeout_err_set", 32'(bus.bus_err), 1);
        chk("timeout_idle", 32'(bus.mem_en), 0);
        repeat (3) step();
        @(negedge clk);
        chk("timeout_err_sticky", 32'(bus.bus_err), 1);

        // Reset in the second busy cycle of a load, late ready afterwards
        step();
        drive(0,0,1,0, 0,'h400,0, 0,0);
        step();
        @(negedge clk);
        chk("rst_busy1_en", 32'(bus.mem_en), 1);
        step();
        drive(1,0,1,0, 0,'h400,0, 0,0);
        @(negedge clk);
        chk("rst_no_valid", 32'(bus.dm_valid), 0);
        step();
        drive(0,0,0,0, 0,0,0, 1,'h999);
        @(negedge clk);
        chk_vec("rst_after", outs(), '0);
        step();
        drive(0,0,0,0, 0,0,0, 0,0);
        @(negedge clk);
        chk_vec("rst_after2", outs(), '0);

        // Stray mem_ready with no requests, then a fetch must start from IDLE
        for (int c = 0; c < 3; c++) begin
            step();
            drive(0,0,0,0, 0,0,0, 1,'h5555);
            @(negedge clk);
            chk_vec($sformatf("stray%0d", c), outs(), '0);
        end
        step();
        drive(0,1,0,0, 'h10,0,0, 0,0);
        @(negedge clk);
        chk("stray_idle_en", 32'(bus.mem_en), 0);
        step();
        @(negedge clk);
        chk("stray_grant_en", 32'(bus.mem_en), 1);
        chk("stray_grant_addr", bus.mem_addr, 'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
